// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit holding 5..9.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= ADJ_THRESH) begin
            q = d + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter with start/busy/done.
// Define BCD_SATURATE_EN to clamp out-of-range inputs to all nines.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned LIMIT = pow10(DIGITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   dig;
    logic [BCD_W-1:0]   dig_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               load;
    logic               over_in;
    logic [BCD_W+BIN_W-1:0] cat;
    logic [BCD_W-1:0]   result;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (dig[g*DIGIT_W +: DIGIT_W]),
            .q (dig_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Carry out of the top digit falls off here, giving bin_in mod 10**DIGITS.
    assign cat = {dig_adj, shreg} << 1;

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign load    = start && (state == IDLE || state == DONE);
    assign over_in = 32'(bin_in) >= LIMIT;

`ifdef BCD_SATURATE_EN
    assign result = ovf_pend ? {DIGITS{4'h9}} : cat[BCD_W+BIN_W-1:BIN_W];
`else
    assign result = cat[BCD_W+BIN_W-1:BIN_W];
`endif

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            dig      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            state    <= SHIFT;
            shreg    <= bin_in;
            dig      <= '0;
            cnt      <= '0;
            ovf_pend <= over_in;
        end else begin
            unique case (state)
                SHIFT: begin
                    shreg <= cat[BIN_W-1:0];
                    dig   <= cat[BCD_W+BIN_W-1:BIN_W];
                    cnt   <= cnt + 1'b1;
                    // Publish on the final shift so data is valid alongside done.
                    if (cnt == LAST) begin
                        state    <= DONE;
                        bcd_out  <= result;
                        overflow <= ovf_pend;
                    end
                end
                DONE:    state <= IDLE;
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard testbench for bin_to_bcd_seq with a decimal-arithmetic reference model.
// Build with BCD_SATURATE_EN defined to check the saturating variant.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .start         (start),
        .bin_in        (bin_in),
        .busy          (busy),
        .done          (done),
        .bcd_out       (bcd_out),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int m;
        logic [15:0] r;
`ifdef BCD_SATURATE_EN
        m = (v >= 10000) ? 9999 : v;
`else
        m = v % 10000;
`endif
        r = '0;
        r[3:0]   = 4'(m % 10);
        r[7:4]   = 4'((m / 10) % 10);
        r[11:8]  = 4'((m / 100) % 10);
        r[15:12] = 4'((m / 1000) % 10);
        return r;
    endfunction

    // One clock cycle of stimulus; records an expectation when the DUT will accept.
    task automatic step(input bit s, input int v);
        exp_t e;
        start  = s;
        bin_in = 14'(v);
        if (s && !busy && rst_n) begin
            e.bcd = ref_bcd(v);
            e.ovf = (v >= 10000);
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit ok;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("bcd_out", int'(bcd_out), int'(e.bcd));
                chk("overflow", int'(overflow), int'(e.ovf));
                chk("latency", cyc - e.cyc, 15);
                ok = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (bcd_out[i*4 +: 4] > 4'd9) ok = 1'b0;
                end
                chk("nibble_range", int'(ok), 1);
            end
        end
    end

    initial begin
        int t;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bcd", int'(bcd_out), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        step(0, 0);

        // Single conversion with busy window check
        step(1, 1234);
        for (int i = 1; i <= 15; i++) begin
            chk("busy_window", int'(busy), (i <= 14) ? 1 : 0);
            if (i == 15) chk("done_at_15", int'(done), 1);
            step(0, 7777);
        end
        step(0, 0);

        // Back-to-back: second start lands in the DONE cycle
        step(1, 0);
        repeat (14) step(0, 3333);
        chk("b2b_done_cycle", int'(done), 1);
        step(1, 9999);
        repeat (16) step(0, 0);

        // Out of range inputs
        step(1, 10000);
        repeat (16) step(0, 0);
        step(1, 16383);
        repeat (16) step(0, 0);

        // Starts while busy are ignored
        step(1, 500);
        step(0, 0);
        step(0, 0);
        step(1, 111);
        repeat (3) step(0, 0);
        step(1, 222);
        repeat (10) step(0, 0);

        // Reset in the middle of a conversion
        step(1, 4321);
        repeat (5) step(0, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_bcd", int'(bcd_out), 0);
        chk("abort_ovf", int'(overflow), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0);
        step(1, 42);
        repeat (16) step(0, 0);

        // Randomized sweep with random gaps and stray starts
        for (int n = 0; n < 40; n++) begin
            step(1, int'($urandom_range(0, 16383)));
            repeat ($urandom_range(0, 20)) begin
                step($urandom_range(0, 3) == 0, int'($urandom_range(0, 16383)));
            end
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            step(0, 0);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
        end
        step(0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
